watch_timekeeper: RTL



---
 rtl/watch_pkg.sv | 12 +
 rtl/watch_tick_gen.sv | 29 ++
 rtl/watch_timekeeper.sv | 110 +++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared time-field constants and run-state enum for the watch
package watch_pkg;
  localparam int TW = 7;
  localparam logic [TW-1:0] SEC_MAX  = 7'd59;
  localparam logic [TW-1:0] MIN_MAX  = 7'd59;
  localparam logic [TW-1:0] HOUR_MAX = 7'd11;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;
endpackage

// File: rtl/watch_tick_gen.sv
// rtl/watch_tick_gen.sv - 1 Hz prescaler, holds its count while disabled
module watch_tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_last;

  assign w_last = (r_pcnt == LAST);
  assign tick   = en & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (clr) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= w_last ? '0 : r_pcnt + 1'b1;
    end
  end
endmodule

// File: rtl/watch_timekeeper.sv
// rtl/watch_timekeeper.sv - 12-hour running clock: preset load, run/stop FSM, sec/min/hour/ap cascade
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          load,
  input  logic          ld_ap,
  input  logic [TW-1:0] ld_hour,
  input  logic [TW-1:0] ld_min,
  output logic          ap,
  output logic [TW-1:0] hour,
  output logic [TW-1:0] min,
  output logic [TW-1:0] sec,
  output logic          sec_tick,
  output logic          min_tick
);
  state_t        r_state;
  state_t        w_state_next;
  logic          w_en;
  logic          w_tick;
  logic [TW-1:0] w_ld_hour;
  logic [TW-1:0] w_ld_min;

  logic          r_ap;
  logic [TW-1:0] r_hour;
  logic [TW-1:0] r_min;
  logic [TW-1:0] r_sec;
  logic          r_sec_tick;
  logic          r_min_tick;

  always_ff @(posedge clk) begin
    if (rst) r_state <= STOPPED;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STOPPED: if (run)  w_state_next = RUNNING;
      RUNNING: if (!run) w_state_next = STOPPED;
      default: w_state_next = STOPPED;
    endcase
  end

  // Enable from the state being entered so a newly raised run counts on the same edge.
  assign w_en = (w_state_next == RUNNING);

  watch_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .clr  (load),
    .tick (w_tick)
  );

  assign w_ld_hour = (ld_hour > HOUR_MAX) ? '0 : ld_hour;
  assign w_ld_min  = (ld_min  > MIN_MAX)  ? '0 : ld_min;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ap       <= 1'b0;
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
    end else if (load) begin
      r_ap       <= ld_ap;
      r_hour     <= w_ld_hour;
      r_min      <= w_ld_min;
      r_sec      <= '0;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
    end else if (w_tick) begin
      r_sec_tick <= 1'b1;
      if (r_sec == SEC_MAX) begin
        r_sec      <= '0;
        r_min_tick <= 1'b1;
        if (r_min == MIN_MAX) begin
          r_min <= '0;
          if (r_hour == HOUR_MAX) begin
            r_hour <= '0;
            r_ap   <= ~r_ap;
          end else begin
            r_hour <= r_hour + 1'b1;
          end
        end else begin
          r_min <= r_min + 1'b1;
        end
      end else begin
        r_sec      <= r_sec + 1'b1;
        r_min_tick <= 1'b0;
      end
    end else begin
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
    end
  end

  assign ap       = r_ap;
  assign hour     = r_hour;
  assign min      = r_min;
  assign sec      = r_sec;
  assign sec_tick = r_sec_tick;
  assign min_tick = r_min_tick;
endmodule
